ldtu_bs_multi: RTL and testbench

- Parametrised multi-channel baseline-subtraction stage for the LiTe-DTU front end.
- Replaces the fixed two-channel, 12-bit subtractor.
- Registers NCH ADC sample words, subtracts a per-channel baseline, and flags valid output.
- Baseline comes from either a manual register value or an on-chip calibration that averages 2^LOG2_NAVG samples per channel.

---
 rtl/ldtu_bs_pkg.sv | 19 +
 rtl/ldtu_bs_chan.sv | 72 +++++++
 rtl/ldtu_bs_multi.sv | 90 +++++++++
 tb/tb_ldtu_bs_multi.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ldtu_bs_pkg.sv
// Shared types and defaults for the LiTe-DTU multi-channel baseline subtractor.
package ldtu_bs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        LOAD  = 2'd2
    } cal_state_t;

    localparam int NCH_DEF       = 2;
    localparam int NBITS_DEF     = 12;
    localparam int NBSL_DEF      = 8;
    localparam int LOG2_NAVG_DEF = 4;

    function automatic int acc_width(input int nbits, input int log2_navg);
        return nbits + log2_navg;
    endfunction

endpackage

// File: rtl/ldtu_bs_chan.sv
// One channel: sample/baseline capture, subtractor, calibration accumulator.
// Zero-clamping on underflow is enabled by LDTU_BS_SATURATE_EN.
module ldtu_bs_chan
    import ldtu_bs_pkg::*;
#(
    parameter int NBITS     = NBITS_DEF,
    parameter int NBSL      = NBSL_DEF,
    parameter int LOG2_NAVG = LOG2_NAVG_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NBITS-1:0] din,
    input  logic             valid,
    input  logic             v1,
    input  logic [NBSL-1:0]  bsl_man,
    input  logic             bsl_mode,
    input  logic             acc_clr,
    input  logic             acc_en,
    input  logic             load,
    output logic [NBITS-1:0] dout,
    output logic [NBSL-1:0]  bsl_auto
);

    localparam int AW = acc_width(NBITS, LOG2_NAVG);

    logic [NBITS-1:0] d1;
    logic [NBSL-1:0]  bsl1;
    logic [NBITS-1:0] bext;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    avg;

    assign bext = NBITS'(bsl1);
    assign avg  = acc >> LOG2_NAVG;

    always_ff @(posedge clk) begin
        if (rst) begin
            d1   <= '0;
            bsl1 <= '0;
            dout <= '0;
        end else begin
            if (valid) begin
                d1   <= din;
                bsl1 <= bsl_mode ? bsl_auto : bsl_man;
            end
            if (v1) begin
`ifdef LDTU_BS_SATURATE_EN
                dout <= (d1 < bext) ? '0 : d1 - bext;
`else
                dout <= d1 - bext;
`endif
            end
        end
    end

    // Average saturates to the largest value the baseline field can hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            bsl_auto <= '0;
        end else begin
            if (acc_clr) begin
                acc <= '0;
            end else if (acc_en) begin
                acc <= acc + AW'(din);
            end
            if (load) begin
                bsl_auto <= (|avg[AW-1:NBSL]) ? '1 : avg[NBSL-1:0];
            end
        end
    end

endmodule

// File: rtl/ldtu_bs_multi.sv
// Multi-channel baseline subtraction with on-chip baseline calibration.
// Optional zero-clamp on underflow: define LDTU_BS_SATURATE_EN.
module ldtu_bs_multi
    import ldtu_bs_pkg::*;
#(
    parameter int NCH       = NCH_DEF,
    parameter int NBITS     = NBITS_DEF,
    parameter int NBSL      = NBSL_DEF,
    parameter int LOG2_NAVG = LOG2_NAVG_DEF
) (
    input  logic                 DCLK,
    input  logic                 rst,
    input  logic [NCH*NBITS-1:0] data_in,
    input  logic                 data_valid,
    input  logic [NCH*NBSL-1:0]  bsl_man,
    input  logic                 bsl_mode,
    input  logic                 cal_start,
    output logic                 cal_busy,
    output logic                 cal_done,
    output logic [NCH*NBSL-1:0]  bsl_auto,
    output logic [NCH*NBITS-1:0] data_out,
    output logic                 data_out_valid,
    output logic                 SeuError
);

    cal_state_t           state;
    logic [LOG2_NAVG-1:0] cnt;
    logic                 v1;
    logic                 acc_clr;
    logic                 acc_en;
    logic                 load;

    assign acc_clr  = (state == IDLE) && cal_start;
    assign acc_en   = (state == ACCUM) && data_valid;
    assign load     = (state == LOAD);
    assign cal_busy = (state != IDLE);
    assign cal_done = (state == LOAD);
    assign SeuError = 1'b0;

    // The counter wraps to zero on the last sample of a calibration run.
    always_ff @(posedge DCLK) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            v1             <= 1'b0;
            data_out_valid <= 1'b0;
        end else begin
            v1             <= data_valid;
            data_out_valid <= v1;
            unique case (state)
                IDLE: begin
                    if (cal_start) begin
                        state <= ACCUM;
                        cnt   <= '0;
                    end
                end
                ACCUM: begin
                    if (data_valid) begin
                        cnt <= cnt + LOG2_NAVG'(1);
                        if (&cnt) state <= LOAD;
                    end
                end
                LOAD:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        ldtu_bs_chan #(
            .NBITS    (NBITS),
            .NBSL     (NBSL),
            .LOG2_NAVG(LOG2_NAVG)
        ) u_chan (
            .clk     (DCLK),
            .rst     (rst),
            .din     (data_in[k*NBITS +: NBITS]),
            .valid   (data_valid),
            .v1      (v1),
            .bsl_man (bsl_man[k*NBSL +: NBSL]),
            .bsl_mode(bsl_mode),
            .acc_clr (acc_clr),
            .acc_en  (acc_en),
            .load    (load),
            .dout    (data_out[k*NBITS +: NBITS]),
            .bsl_auto(bsl_auto[k*NBSL +: NBSL])
        );
    end

endmodule

// File: tb/tb_ldtu_bs_multi.sv
// Directed bench for ldtu_bs_multi (NCH=2, NBITS=12, NBSL=8, LOG2_NAVG=4).
module tb_ldtu_bs_multi;

    logic        DCLK = 1'b0;
    logic        rst;
    logic [23:0] data_in;
    logic        data_valid;
    logic [15:0] bsl_man;
    logic        bsl_mode;
    logic        cal_start;
    logic        cal_busy;
    logic        cal_done;
    logic [15:0] bsl_auto;
    logic [23:0] data_out;
    logic        data_out_valid;
    logic        SeuError;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [11:0] d0, d1;
        logic [7:0]  b0, b1;
        logic [11:0] e0, e1;
    } vec_t;

    vec_t vt[5];

    ldtu_bs_multi #(
        .NCH(2), .NBITS(12), .NBSL(8), .LOG2_NAVG(4)
    ) dut (
        .DCLK          (DCLK),
        .rst           (rst),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .bsl_man       (bsl_man),
        .bsl_mode      (bsl_mode),
        .cal_start     (cal_start),
        .cal_busy      (cal_busy),
        .cal_done      (cal_done),
        .bsl_auto      (bsl_auto),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .SeuError      (SeuError)
    );

    always #5 DCLK = ~DCLK;

    task automatic tick();
        @(posedge DCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    initial begin
        int n;
        int early;
        int dones;

        vt[0] = '{d0: 12'h100, d1: 12'h0FF, b0: 8'h20, b1: 8'hFF,
                  e0: 12'h0E0, e1: 12'h000};
`ifdef LDTU_BS_SATURATE_EN
        vt[1] = '{d0: 12'h010, d1: 12'h005, b0: 8'h20, b1: 8'h00,
                  e0: 12'h000, e1: 12'h005};
        vt[2] = '{d0: 12'h020, d1: 12'h000, b0: 8'h20, b1: 8'h01,
                  e0: 12'h000, e1: 12'h000};
`else
        vt[1] = '{d0: 12'h010, d1: 12'h005, b0: 8'h20, b1: 8'h00,
                  e0: 12'hFF0, e1: 12'h005};
        vt[2] = '{d0: 12'h020, d1: 12'h000, b0: 8'h20, b1: 8'h01,
                  e0: 12'h000, e1: 12'hFFF};
`endif
        vt[3] = '{d0: 12'hFFF, d1: 12'h800, b0: 8'hFF, b1: 8'h01,
                  e0: 12'hF00, e1: 12'h7FF};
        vt[4] = '{d0: 12'h0FF, d1: 12'h100, b0: 8'hFF, b1: 8'h00,
                  e0: 12'h000, e1: 12'h100};

        // Reset dominates an active valid input
        rst = 1'b1;
        data_valid = 1'b1;
        data_in = 24'hFFF_FFF;
        bsl_man = 16'h0;
        bsl_mode = 1'b0;
        cal_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_dout", data_out, 0);
            chk("rst_valid", data_out_valid, 0);
            chk("rst_bsl_auto", bsl_auto, 0);
            chk("rst_busy", cal_busy, 0);
        end
        rst = 1'b0;
        data_valid = 1'b0;
        chk("seu", SeuError, 0);

        // Table: single valid sample, output after exactly two edges
        for (int i = 0; i < 5; i++) begin
            data_in = {vt[i].d1, vt[i].d0};
            bsl_man = {vt[i].b1, vt[i].b0};
            data_valid = 1'b1;
            tick();
            chk("vec_lat1", data_out_valid, 0);
            data_valid = 1'b0;
            data_in = 24'hABC_DEF;
            tick();
            chk("vec_valid", data_out_valid, 1);
            chk("vec_ch0", data_out[11:0], vt[i].e0);
            chk("vec_ch1", data_out[23:12], vt[i].e1);
            tick();
            chk("vec_pulse", data_out_valid, 0);
            chk("vec_hold", data_out, {vt[i].e1, vt[i].e0});
        end

        // Back-to-back samples stream out back-to-back
        bsl_man = 16'h0;
        data_valid = 1'b1;
        data_in = 24'h111_222;
        tick();
        data_in = 24'h333_444;
        tick();
        data_valid = 1'b0;
        chk("b2b_v0", data_out_valid, 1);
        chk("b2b_d0", data_out, 24'h111_222);
        tick();
        chk("b2b_v1", data_out_valid, 1);
        chk("b2b_d1", data_out, 24'h333_444);
        tick();
        chk("b2b_end", data_out_valid, 0);

        // Calibration with gaps and a stray cal_start mid-run
        cal_start = 1'b1;
        tick();
        cal_start = 1'b0;
        chk("cal_busy_start", cal_busy, 1);
        n = 0;
        early = 0;
        for (int c = 0; c < 40 && n < 16; c++) begin
            data_valid = (c % 3) != 2;
            data_in = {12'h400, (n % 2 == 0) ? 12'h030 : 12'h032};
            cal_start = (c == 4);
            tick();
            if (data_valid) n++;
            if (n < 16 && cal_done) early++;
        end
        data_valid = 1'b0;
        cal_start = 1'b0;
        chk("cal_samples", n, 16);
        chk("cal_early_done", early, 0);
        chk("cal_done", cal_done, 1);
        chk("cal_busy_load", cal_busy, 1);
        chk("cal_bsl_old", bsl_auto, 16'h0);
        tick();
        chk("cal_done_pulse", cal_done, 0);
        chk("cal_busy_end", cal_busy, 0);
        chk("cal_bsl_auto", bsl_auto, 16'hFF31);

        // Mode switch between calibrated and manual baselines
        bsl_mode = 1'b1;
        data_in = 24'h1FF_131;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        tick();
        chk("mode_auto", data_out, 24'h100_100);
        bsl_mode = 1'b0;
        bsl_man = 16'h0001;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        tick();
        chk("mode_man", data_out, 24'h1FF_130);

        // Abort calibration with reset after 8 samples
        dones = 0;
        cal_start = 1'b1;
        tick();
        cal_start = 1'b0;
        data_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            dones += int'(cal_done);
        end
        data_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", cal_busy, 0);
        chk("abort_bsl", bsl_auto, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            dones += int'(cal_done);
        end
        chk("abort_no_done", dones, 0);
        chk("abort_idle", cal_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
